// File: rtl/ibuf_offset_cal.sv
// ibuf_offset_cal: offset-trim calibration sequencer for one differential input
// buffer. It sweeps the sign-magnitude trim code from -7 to +7 and
// majority-samples the synchronized buffer output at each code. The first code
// whose majority reads high becomes the calibrated code.
// Optional build macro IBUF_CAL_REFINE_EN: on a trip, pick whichever of the
// tripping code and its predecessor sampled closest to a 50% ones ratio.
module ibuf_offset_cal #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_COUNT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       o_in,
  output logic [3:0] osc,
  output logic [1:0] osc_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] cal_code,
  output logic       cal_valid,
  output logic       cal_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         sync_q;
  logic [CW-1:0]      cnt;
  logic [7:0]         ones;
  logic signed [3:0]  s;
  logic               active;
  logic               trip;
  logic [3:0]         trip_code;

  // Sign-magnitude trim code for sweep index v; zero maps to positive zero.
  function automatic logic [3:0] code_of(input logic signed [3:0] v);
    logic signed [3:0] m;
    m = -v;
    if (v < 0) return {1'b0, m[2:0]};
    else       return {1'b1, v[2:0]};
  endfunction

`ifdef IBUF_CAL_REFINE_EN
  logic [7:0] prev_ones;

  // Distance of a ones count from the ideal 50% point.
  function automatic logic [7:0] dist_half(input logic [7:0] x);
    logic [7:0] half;
    half = 8'(SAMPLE_COUNT / 2);
    return (x > half) ? (x - half) : (half - x);
  endfunction
`endif

  assign active = (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_EVAL);
  assign trip   = ({1'b0, ones} << 1) > 9'(SAMPLE_COUNT);

  // Result code for a trip; refinement may step back to the previous code.
  always_comb begin
    trip_code = code_of(s);
`ifdef IBUF_CAL_REFINE_EN
    if (dist_half(prev_ones) < dist_half(ones)) trip_code = code_of(s - 4'sd1);
`endif
  end

  // Two-flop synchronizer for the asynchronous buffer output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], o_in};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_nx = state;
    osc      = cal_code;
    osc_en   = 2'b00;
    busy     = 1'b0;
    done     = 1'b0;
    if (active) begin
      osc    = code_of(s);
      osc_en = 2'b11;
      busy   = 1'b1;
    end
    unique case (state)
      ST_IDLE:   if (start) state_nx = ST_SETTLE;
      ST_SETTLE: if (abort) state_nx = ST_IDLE;
                 else if (cnt == SET_LAST) state_nx = ST_SAMPLE;
      ST_SAMPLE: if (abort) state_nx = ST_IDLE;
                 else if (cnt == SMP_LAST) state_nx = ST_EVAL;
      ST_EVAL:   if (abort) state_nx = ST_IDLE;
                 else if (trip || (s == 4'sd7)) state_nx = ST_DONE;
                 else state_nx = ST_SETTLE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Sweep counters, sample accumulation and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ones      <= '0;
      s         <= '0;
      cal_code  <= 4'b1000;
      cal_valid <= 1'b0;
      cal_err   <= 1'b0;
`ifdef IBUF_CAL_REFINE_EN
      prev_ones <= '0;
`endif
    end else if (active && abort) begin
      // Abort outranks any evaluation result in the same cycle.
      cnt       <= '0;
      ones      <= '0;
      cal_valid <= 1'b0;
      cal_err   <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          s    <= -4'sd7;
          cnt  <= '0;
          ones <= '0;
        end
        ST_SETTLE: begin
          if (cnt == SET_LAST) begin
            cnt  <= '0;
            ones <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (sync_q[1] == 1'b1) ones <= ones + 8'd1;
          if (cnt == SMP_LAST) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
        end
        ST_EVAL: begin
          if (trip && (s == -4'sd7)) begin
            cal_code  <= 4'b0111;
            cal_valid <= 1'b0;
            cal_err   <= 1'b1;
          end else if (trip) begin
            cal_code  <= trip_code;
            cal_valid <= 1'b1;
            cal_err   <= 1'b0;
          end else if (s == 4'sd7) begin
            cal_code  <= 4'b1111;
            cal_valid <= 1'b0;
            cal_err   <= 1'b1;
          end else begin
            s <= s + 4'sd1;
`ifdef IBUF_CAL_REFINE_EN
            prev_ones <= ones;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_offset_cal.sv
// tb_ibuf_offset_cal: directed bench for ibuf_offset_cal with a behavioural
// buffer model (output high when offset + 5*trim > 0) and a toggling source
// that yields exactly half ones per sample window.
module tb_ibuf_offset_cal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       o_in;
  logic [3:0] osc;
  logic [1:0] osc_en;
  logic       busy;
  logic       done;
  logic [3:0] cal_code;
  logic       cal_valid;
  logic       cal_err;

  int   checks = 0;
  int   errors = 0;
  int   offset = 0;
  logic tog_mode = 1'b0;
  logic tog = 1'b0;
  int   trim;

  ibuf_offset_cal #(
    .SETTLE_CYCLES (8),
    .SAMPLE_COUNT  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .o_in      (o_in),
    .osc       (osc),
    .osc_en    (osc_en),
    .busy      (busy),
    .done      (done),
    .cal_code  (cal_code),
    .cal_valid (cal_valid),
    .cal_err   (cal_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tog <= ~tog;

  // Buffer model: trim applies only with the trim path fully enabled.
  always_comb begin
    trim = 0;
    if (osc_en == 2'b11)
      trim = osc[3] ? 5 * int'({29'd0, osc[2:0]}) : -5 * int'({29'd0, osc[2:0]});
    o_in = tog_mode ? tog : ((offset + trim) > 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start, check the first-cycle outputs, then count cycles until done.
  task automatic run_cal(input int off, input logic tm, output int lat);
    offset   = off;
    tog_mode = tm;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("first_busy", busy, 1'b1);
    check("first_osc_en", osc_en, 2'b11);
    check("first_osc", osc, 4'b0111);
    lat = 0;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) check("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic do_case(input string tag, input int off, input logic tm, input int exp_lat,
                         input logic [3:0] exp_code, input logic exp_valid, input logic exp_err);
    int lat;
    run_cal(off, tm, lat);
    $display("case %s: latency %0d", tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_code"}, cal_code, exp_code);
    check({tag, "_valid"}, cal_valid, exp_valid);
    check({tag, "_err"}, cal_err, exp_err);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_osc_en_idle"}, osc_en, 2'b00);
    check({tag, "_osc_idle"}, osc, exp_code);
  endtask

  initial begin
    int seen;
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    check("rst_osc", osc, 4'b1000);
    check("rst_osc_en", osc_en, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cal_code", cal_code, 4'b1000);
    check("rst_cal_valid", cal_valid, 1'b0);
    check("rst_cal_err", cal_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_case("off_p12", 12, 1'b0, 151, 4'b0010, 1'b1, 1'b0);
    do_case("off_m23", -23, 1'b0, 326, 4'b1101, 1'b1, 1'b0);
    do_case("off_p50", 50, 1'b0, 26, 4'b0111, 1'b0, 1'b1);
    do_case("off_m50", -50, 1'b0, 376, 4'b1111, 1'b0, 1'b1);
    // Exactly half ones per window never satisfies the strict majority.
    do_case("half_ones", 0, 1'b1, 376, 4'b1111, 1'b0, 1'b1);

    // Abort mid-sweep; a second start while busy must not restart the sweep.
    offset   = 12;
    tog_mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("busy_start_ignored_osc", osc, 4'b0110);
    check("abort_pre_busy", busy, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_osc_en", osc_en, 2'b00);
    check("abort_err", cal_err, 1'b1);
    check("abort_valid", cal_valid, 1'b0);
    check("abort_code_kept", cal_code, 4'b1111);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a SAMPLE phase.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_osc", osc, 4'b1000);
    check("arst_osc_en", osc_en, 2'b00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_cal_code", cal_code, 4'b1000);
    check("arst_cal_valid", cal_valid, 1'b0);
    check("arst_cal_err", cal_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cal(12, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd151);
    check("post_rst_code", cal_code, 4'b0010);
    check("post_rst_valid", cal_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
